// File: rtl/ins_reg_gen.sv
// Instruction register: assembles opcode + operand bytes
// from a byte-serial fetch stream behind valid/ready.
//
// Ports:
//   clk, rst (async, active-low)
//   flush      : sync abort of partial/held instruction
//   data       : fetch byte
//   data_valid : byte offered this cycle
//   data_ready : byte accepted this cycle (comb)
//   ins        : opcode of held instruction
//   ad1        : register address field
//   ad2        : operand bytes, first byte lowest
//   ins_len    : operand byte count
//   ins_valid  : complete instruction held
//   ins_ack    : consumer takes held instruction
module ins_reg_gen #(
  parameter int          DW        = 8,
  parameter int          OPW       = 4,
  parameter int          NOPS      = 2,
  parameter logic [31:0] LEN_TABLE = 32'h0000_5A50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [DW-1:0]      data,
  input  logic               data_valid,
  output logic               data_ready,
  output logic [OPW-1:0]     ins,
  output logic [DW-OPW-1:0]  ad1,
  output logic [NOPS*DW-1:0] ad2,
  output logic [2:0]         ins_len,
  output logic               ins_valid,
  input  logic               ins_ack
);

  localparam int CW = $clog2(NOPS) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [OPW-1:0]     r_ins;
  logic [DW-OPW-1:0]  r_ad1;
  logic [NOPS*DW-1:0] r_ad2;
  logic [2:0]         r_len;
  logic               r_valid;

  logic               w_ready;
  logic               w_xfer;
  logic [OPW-1:0]     w_op;
  logic [2:0]         w_len;
  logic [2:0]         w_cnt_nxt;

  // Operand count lookup, saturated to NOPS.
  function automatic logic [2:0] f_len(
    input logic [OPW-1:0] op
  );
    logic [1:0] l;
    l = LEN_TABLE[2*int'(op) +: 2];
    if (int'(l) > NOPS)
      return 3'(NOPS);
    return {1'b0, l};
  endfunction

  // Ready is combinational so an ack in HOLD can
  // pass the next opcode byte through without a bubble.
  assign w_ready   = !flush &&
                     ((r_state != HOLD) || ins_ack);
  assign w_xfer    = data_valid && w_ready;
  assign w_op      = data[DW-1:DW-OPW];
  assign w_len     = f_len(w_op);
  assign w_cnt_nxt = 3'(r_cnt) + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ins   <= '0;
      r_ad1   <= '0;
      r_ad2   <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, HOLD: begin
          if (w_xfer) begin
            r_ins <= w_op;
            r_ad1 <= data[DW-OPW-1:0];
            r_ad2 <= '0;
            r_len <= w_len;
            r_cnt <= '0;
            if (w_len == 3'd0) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end else begin
              r_state <= OPER;
              r_valid <= 1'b0;
            end
          end else if (r_state == HOLD && ins_ack) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        OPER: begin
          if (w_xfer) begin
            for (int i = 0; i < NOPS; i++) begin
              if (int'(r_cnt) == i)
                r_ad2[i*DW +: DW] <= data;
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_nxt == r_len) begin
              r_state <= HOLD;
              r_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = w_ready;
  assign ins        = r_ins;
  assign ad1        = r_ad1;
  assign ad2        = r_ad2;
  assign ins_len    = r_len;
  assign ins_valid  = r_valid;

endmodule

// File: tb/tb_ins_reg_gen.sv
// Directed bench for ins_reg_gen.
// Table: op2=1, op3=2, op8=3 (saturates to NOPS=2), op0=0.
module tb_ins_reg_gen;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  ins;
  logic [3:0]  ad1;
  logic [15:0] ad2;
  logic [2:0]  ins_len;
  logic        ins_valid;
  logic        ins_ack;

  int n_chk;
  int n_fail;

  ins_reg_gen #(
    .DW(8), .OPW(4), .NOPS(2),
    .LEN_TABLE(32'h0003_5A90)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .ins(ins), .ad1(ad1),
    .ad2(ad2), .ins_len(ins_len),
    .ins_valid(ins_valid), .ins_ack(ins_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] d,
                      input logic v,
                      input logic a,
                      input logic f);
    data       = d;
    data_valid = v;
    ins_ack    = a;
    flush      = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    flush = 1'b0;
    data = 8'h00;
    data_valid = 1'b0;
    ins_ack = 1'b0;
    #12;
    chk("rst_ins", 32'(ins), 32'h0);
    chk("rst_ad2", 32'(ad2), 32'h0);
    chk("rst_len", 32'(ins_len), 32'h0);
    chk("rst_valid", 32'(ins_valid), 32'h0);
    chk("rst_ready", 32'(data_ready), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 3A 55 AA back to back
    step(8'h3A, 1, 0, 0);
    chk("op3_ins", 32'(ins), 32'h3);
    chk("op3_ad1", 32'(ad1), 32'hA);
    chk("op3_len", 32'(ins_len), 32'h2);
    chk("op3_v0", 32'(ins_valid), 32'h0);
    step(8'h55, 1, 0, 0);
    chk("op3_v1", 32'(ins_valid), 32'h0);
    step(8'hAA, 1, 0, 0);
    chk("op3_valid", 32'(ins_valid), 32'h1);
    chk("op3_ad2", 32'(ad2), 32'hAA55);
    data = 8'hFF;
    #1;
    chk("hold_ready", 32'(data_ready), 32'h0);
    step(8'hFF, 1, 0, 0);
    chk("hold_ad2", 32'(ad2), 32'hAA55);
    chk("hold_valid", 32'(ins_valid), 32'h1);

    // ack + next opcode in the same cycle
    data = 8'h2B;
    ins_ack = 1'b1;
    #1;
    chk("b2b_ready", 32'(data_ready), 32'h1);
    step(8'h2B, 1, 1, 0);
    chk("b2b_ins", 32'(ins), 32'h2);
    chk("b2b_ad1", 32'(ad1), 32'hB);
    chk("b2b_valid", 32'(ins_valid), 32'h0);
    chk("b2b_ad2", 32'(ad2), 32'h0);
    chk("b2b_len", 32'(ins_len), 32'h1);
    step(8'hC4, 1, 0, 0);
    chk("op2_valid", 32'(ins_valid), 32'h1);
    chk("op2_ad2", 32'(ad2), 32'h00C4);

    // ack without transfer
    step(8'h00, 0, 1, 0);
    chk("ack_valid", 32'(ins_valid), 32'h0);
    chk("ack_keep", 32'(ins), 32'h2);

    // zero-operand opcode
    step(8'h07, 1, 0, 0);
    chk("op0_valid", 32'(ins_valid), 32'h1);
    chk("op0_ad1", 32'(ad1), 32'h7);
    chk("op0_ad2", 32'(ad2), 32'h0);
    chk("op0_len", 32'(ins_len), 32'h0);
    step(8'h00, 0, 1, 0);

    // gaps of 3 cycles between operands
    step(8'h3A, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 0, 0, 0);
      chk("gap_v", 32'(ins_valid), 32'h0);
    end
    step(8'h55, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 0, 0, 0);
      chk("gap_ready", 32'(data_ready), 32'h1);
    end
    step(8'hAA, 1, 0, 0);
    chk("gap_valid", 32'(ins_valid), 32'h1);
    chk("gap_ad2", 32'(ad2), 32'hAA55);
    step(8'h00, 0, 1, 0);

    // flush after first operand
    step(8'h3A, 1, 0, 0);
    step(8'h55, 1, 0, 0);
    data = 8'hAA;
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(data_ready), 32'h0);
    step(8'hAA, 1, 0, 1);
    chk("fl_valid", 32'(ins_valid), 32'h0);
    chk("fl_ad2", 32'(ad2), 32'h0055);
    chk("fl_ins", 32'(ins), 32'h3);
    step(8'h07, 1, 0, 0);
    chk("fl_op", 32'(ins), 32'h0);
    chk("fl_op_v", 32'(ins_valid), 32'h1);
    step(8'h00, 0, 1, 0);

    // saturated length
    step(8'h81, 1, 0, 0);
    chk("sat_len", 32'(ins_len), 32'h2);
    step(8'h01, 1, 0, 0);
    step(8'h02, 1, 0, 0);
    chk("sat_valid", 32'(ins_valid), 32'h1);
    chk("sat_ad2", 32'(ad2), 32'h0201);
    step(8'h00, 0, 1, 0);

    // async reset mid-OPER
    step(8'h3A, 1, 0, 0);
    step(8'h55, 1, 0, 0);
    data_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_ins", 32'(ins), 32'h0);
    chk("ar_ad1", 32'(ad1), 32'h0);
    chk("ar_ad2", 32'(ad2), 32'h0);
    chk("ar_len", 32'(ins_len), 32'h0);
    chk("ar_valid", 32'(ins_valid), 32'h0);
    #1;
    rst = 1'b1;
    step(8'h3A, 1, 0, 0);
    step(8'h11, 1, 0, 0);
    chk("ar_mid", 32'(ins_valid), 32'h0);
    step(8'h22, 1, 0, 0);
    chk("ar2_valid", 32'(ins_valid), 32'h1);
    chk("ar2_ad2", 32'(ad2), 32'h2211);
    step(8'h00, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
